// File: rtl/rv_irq_timer_pkg.sv
// ---------------------------------------------------------------------------
// rv_irq_timer_pkg
//
// Shared constants and helpers for the multi-channel interrupt timer.
//
// Contents:
//    TIMER_DEF_N_CH      default number of channels
//    TIMER_DEF_CNT_W     default counter/period width
//    TIMER_DEF_PERIOD    period loaded into every channel at reset; matches
//                        the 10_000-cycle interval of the old fixed counter
//    CFG_OFS_*           bit offsets of the fields inside the packed
//                        per-channel configuration word
//    ch_idx_w()          width of the channel-index port
//    cfg_w()             width of the packed configuration word
// ---------------------------------------------------------------------------
package rv_irq_timer_pkg;

   localparam int unsigned TIMER_DEF_N_CH   = 4;
   localparam int unsigned TIMER_DEF_CNT_W  = 24;
   localparam int unsigned TIMER_DEF_PERIOD = 10_000;

   // Layout of the configuration word handed from the top to each channel:
   // oneshot in bit 0, enable in bit 1, period in the bits above.
   localparam int unsigned CFG_OFS_ONESHOT = 0;
   localparam int unsigned CFG_OFS_EN      = 1;
   localparam int unsigned CFG_OFS_PERIOD  = 2;

   // Channel-index width. Forcing the low bit keeps the index at least one
   // bit wide for a single-channel build and, for the default four channels,
   // leaves room to present an out-of-range index that must be ignored.
   function automatic int unsigned ch_idx_w(input int unsigned n_ch);
      int unsigned w;
      w = $clog2(n_ch);
      return w | 1;
   endfunction

   // Total width of the packed configuration word for a given counter width.
   function automatic int unsigned cfg_w(input int unsigned cnt_w);
      return cnt_w + CFG_OFS_PERIOD;
   endfunction

endpackage

// File: rtl/rv_irq_timer_ch.sv
// ---------------------------------------------------------------------------
// rv_irq_timer_ch
//
// One timer channel. Counts clk cycles up to a programmable period and,
// on expiry, raises a one-cycle tick together with a sticky pending flag.
// In one-shot mode the channel disables itself on its first expiry.
//
// Parameters:
//    CNT_W        counter/period width
//    DEF_PERIOD   period loaded at reset
//    RST_EN       enable state at reset (periodic mode)
//
// Ports:
//    clk          clock
//    rst          synchronous reset, active-high
//    cfg_we       write strobe for this channel (already decoded)
//    cfg_word     packed {period, en, oneshot}; see CFG_OFS_* in the package
//    ack          pending clear, level-sensitive
//    tick         one-cycle pulse, high the cycle after the count expires
//    pend         sticky pending flag
// ---------------------------------------------------------------------------
module rv_irq_timer_ch
   import rv_irq_timer_pkg::*;
#(
   parameter int unsigned      CNT_W      = TIMER_DEF_CNT_W,
   parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(TIMER_DEF_PERIOD),
   parameter logic             RST_EN     = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [cfg_w(CNT_W)-1:0] cfg_word,
   input  logic                    ack,
   output logic                    tick,
   output logic                    pend
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] period;
   logic             en;
   logic             oneshot;

   logic [CNT_W-1:0] last_count;
   logic             active;
   logic             expire;

   logic [CNT_W-1:0] new_period;
   logic             new_en;
   logic             new_oneshot;

   // Unpack the configuration word into its fields.
   assign new_period  = cfg_word[CFG_OFS_PERIOD +: CNT_W];
   assign new_en      = cfg_word[CFG_OFS_EN];
   assign new_oneshot = cfg_word[CFG_OFS_ONESHOT];

   // The channel only runs when enabled with a non-zero period. Expiry is an
   // equality compare against period-1, so the counter never runs past the
   // period and the modulo arithmetic never has to wrap. A configuration
   // write in the expiry cycle takes priority and suppresses the tick.
   always_comb begin
      last_count = period - 1'b1;
      active     = en && (period != '0);
      expire     = active && (count == last_count) && !cfg_we;
   end

   // Counter and configuration registers. A write reloads the whole channel
   // configuration and restarts the count from zero. On expiry the count
   // returns to zero; a one-shot channel also drops its enable, so it sits
   // at zero until reprogrammed.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         period  <= DEF_PERIOD;
         en      <= RST_EN;
         oneshot <= 1'b0;
      end else if (cfg_we) begin
         count   <= '0;
         period  <= new_period;
         en      <= new_en;
         oneshot <= new_oneshot;
      end else if (expire) begin
         count <= '0;
         if (oneshot) begin
            en <= 1'b0;
         end
      end else if (active) begin
         count <= count + 1'b1;
      end
   end

   // Tick and pending flag. Both are set on the same edge, so pend rises
   // together with tick. ack clears pend, but a fresh expiry in the same
   // cycle wins so an interrupt is never lost. A config write leaves pend
   // alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick <= 1'b0;
         pend <= 1'b0;
      end else begin
         tick <= expire;
         pend <= (pend && !ack) || expire;
      end
   end

endmodule

// File: rtl/rv_irq_timer.sv
// ---------------------------------------------------------------------------
// rv_irq_timer
//
// Multi-channel periodic/one-shot interrupt timer for the rv_sopc system.
// Each channel counts clk cycles to its own period and emits a one-cycle
// tick plus a sticky pending bit; irq is the OR of all pending bits and
// feeds the core's interrupt input. Out of reset, channel 0 runs periodic
// at DEF_PERIOD, which reproduces the old fixed 10_000-cycle interrupt.
//
// Parameters:
//    N_CH         number of channels (1..16)
//    CNT_W        counter/period width
//    DEF_PERIOD   period loaded into every channel at reset
//    RST_EN       per-channel enable mask at reset
//
// Ports:
//    clk          clock, sole clock domain
//    rst          synchronous reset, active-high
//    cfg_we       config write strobe, one channel per cycle
//    cfg_ch       channel index for cfg_we; indices >= N_CH are ignored
//    cfg_period   period in cycles; 0 halts the channel
//    cfg_en       channel enable
//    cfg_oneshot  1 = one-shot, 0 = periodic
//    ack          per-channel pending clear, level
//    tick         per-channel one-cycle expiry pulse
//    pend         per-channel sticky pending flags
//    irq          OR of pend
// ---------------------------------------------------------------------------
module rv_irq_timer
   import rv_irq_timer_pkg::*;
#(
   parameter int unsigned      N_CH       = TIMER_DEF_N_CH,
   parameter int unsigned      CNT_W      = TIMER_DEF_CNT_W,
   parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(TIMER_DEF_PERIOD),
   parameter logic [N_CH-1:0]  RST_EN     = N_CH'(1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic [ch_idx_w(N_CH)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]          cfg_period,
   input  logic                      cfg_en,
   input  logic                      cfg_oneshot,
   input  logic [N_CH-1:0]           ack,
   output logic [N_CH-1:0]           tick,
   output logic [N_CH-1:0]           pend,
   output logic                      irq
);

   localparam int unsigned CH_IDX_W = ch_idx_w(N_CH);
   localparam int unsigned CFG_W    = cfg_w(CNT_W);

   logic [CFG_W-1:0] cfg_word;
   logic [N_CH-1:0]  ch_we;

   // Pack the write data once; every channel sees the same word and only
   // the addressed one latches it.
   always_comb begin
      cfg_word = '0;
      cfg_word[CFG_OFS_PERIOD +: CNT_W] = cfg_period;
      cfg_word[CFG_OFS_EN]              = cfg_en;
      cfg_word[CFG_OFS_ONESHOT]         = cfg_oneshot;
   end

   // Decode the channel index into one-hot write enables. The compare is on
   // the full index width, so an index at or beyond N_CH matches no channel
   // and the write simply has no effect.
   always_comb begin
      ch_we = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         ch_we[i] = cfg_we && (cfg_ch == CH_IDX_W'(i));
      end
   end

   // One independent channel per index.
   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      rv_irq_timer_ch #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD),
         .RST_EN     (RST_EN[i])
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .cfg_we   (ch_we[i]),
         .cfg_word (cfg_word),
         .ack      (ack[i]),
         .tick     (tick[i]),
         .pend     (pend[i])
      );
   end

   // The interrupt follows the registered pending flags directly, with no
   // extra pipeline stage, and stays high until every flag is acknowledged.
   assign irq = |pend;

endmodule

// File: tb/tb_rv_irq_timer.sv
// ---------------------------------------------------------------------------
// tb_rv_irq_timer
//
// Directed bench for rv_irq_timer with the default configuration
// (4 channels, 24-bit counters, 10_000-cycle reset period, channel 0 only
// enabled at reset). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so every check sees the state
// left behind by the edge just taken.
// ---------------------------------------------------------------------------
module tb_rv_irq_timer;

   localparam int unsigned N_CH     = 4;
   localparam int unsigned CNT_W    = 24;
   localparam int unsigned CH_IDX_W = 3;

   logic                clk;
   logic                rst;
   logic                cfg_we;
   logic [CH_IDX_W-1:0] cfg_ch;
   logic [CNT_W-1:0]    cfg_period;
   logic                cfg_en;
   logic                cfg_oneshot;
   logic [N_CH-1:0]     ack;
   logic [N_CH-1:0]     tick;
   logic [N_CH-1:0]     pend;
   logic                irq;

   int checkCount;
   int errCount;
   int badTicks;

   logic [N_CH-1:0] expTick;
   logic [N_CH-1:0] expPend;

   rv_irq_timer #(
      .N_CH       (N_CH),
      .CNT_W      (CNT_W),
      .DEF_PERIOD (24'd10_000),
      .RST_EN     (4'b0001)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_period  (cfg_period),
      .cfg_en      (cfg_en),
      .cfg_oneshot (cfg_oneshot),
      .ack         (ack),
      .tick        (tick),
      .pend        (pend),
      .irq         (irq)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [CH_IDX_W-1:0] ch,
                                input logic [CNT_W-1:0] per, input logic en,
                                input logic os, input logic [N_CH-1:0] ackv);
      cfg_we      = we;
      cfg_ch      = ch;
      cfg_period  = per;
      cfg_en      = en;
      cfg_oneshot = os;
      ack         = ackv;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'd0, 24'd0, 1'b0, 1'b0, 4'b0000);
   endtask

   task automatic checkOutput(input string tag, input logic [N_CH-1:0] eTick,
                              input logic [N_CH-1:0] ePend, input logic eIrq);
      checkCount++;
      assert (tick === eTick) else begin
         errCount++;
         $error("[TB] FAIL %s.tick observed=%b expected=%b", tag, tick, eTick);
      end
      checkCount++;
      assert (pend === ePend) else begin
         errCount++;
         $error("[TB] FAIL %s.pend observed=%b expected=%b", tag, pend, ePend);
      end
      checkCount++;
      assert (irq === eIrq) else begin
         errCount++;
         $error("[TB] FAIL %s.irq observed=%b expected=%b", tag, irq, eIrq);
      end
   endtask

   task automatic checkValue(input string tag, input int observed, input int expected);
      checkCount++;
      assert (observed == expected) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance n edges and count the edges after which any tick was high.
   task automatic waitQuiet(input int n, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (tick !== '0) bad++;
      end
   endtask

   initial begin
      checkCount = 0;
      errCount   = 0;
      rst        = 1'b1;
      idle();

      // Reset state.
      step();
      step();
      checkOutput("reset", 4'b0000, 4'b0000, 1'b0);

      // Channel 0 out of reset: first tick 10_000 edges after release.
      rst = 1'b0;
      waitQuiet(9_999, badTicks);
      checkValue("ch0_first_quiet", badTicks, 0);
      step();
      checkOutput("ch0_first_tick", 4'b0001, 4'b0001, 1'b1);

      // Acknowledge, then the next tick exactly 10_000 edges after the first.
      applyStimulus(1'b0, 3'd0, 24'd0, 1'b0, 1'b0, 4'b0001);
      step();
      checkOutput("ch0_ack", 4'b0000, 4'b0000, 1'b0);
      idle();
      waitQuiet(9_998, badTicks);
      checkValue("ch0_second_quiet", badTicks, 0);
      step();
      checkOutput("ch0_second_tick", 4'b0001, 4'b0001, 1'b1);

      // Stop channel 0 and clear its pend in the same cycle.
      applyStimulus(1'b1, 3'd0, 24'd10_000, 1'b0, 1'b0, 4'b0001);
      step();
      checkOutput("ch0_stop", 4'b0000, 4'b0000, 1'b0);

      // ch1 period 5 periodic (written at k=0), ch2 period 7 one-shot (k=1).
      applyStimulus(1'b1, 3'd1, 24'd5, 1'b1, 1'b0, 4'b0000);
      step();
      checkOutput("ch1_write", 4'b0000, 4'b0000, 1'b0);
      applyStimulus(1'b1, 3'd2, 24'd7, 1'b1, 1'b1, 4'b0000);
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 1) idle();
         expTick = {1'b0, (k == 8), (k % 5 == 0), 1'b0};
         expPend = {1'b0, (k >= 8), (k >= 5), 1'b0};
         checkOutput($sformatf("seq_k%0d", k), expTick, expPend, (k >= 5));
      end

      // k=21..24 quiet, then ack ch1/ch2 during the edge where ch1 expires.
      waitQuiet(4, badTicks);
      checkValue("pre_collide_quiet", badTicks, 0);
      applyStimulus(1'b0, 3'd0, 24'd0, 1'b0, 1'b0, 4'b0110);
      step();
      checkOutput("ack_collide", 4'b0010, 4'b0010, 1'b1);
      applyStimulus(1'b0, 3'd0, 24'd0, 1'b0, 1'b0, 4'b0010);
      step();
      checkOutput("ack_clear", 4'b0000, 4'b0000, 1'b0);
      applyStimulus(1'b1, 3'd1, 24'd5, 1'b0, 1'b0, 4'b0000);
      step();
      checkOutput("ch1_stop", 4'b0000, 4'b0000, 1'b0);

      // ch0 period 3; rewrite while count==2 so the write beats the expiry.
      applyStimulus(1'b1, 3'd0, 24'd3, 1'b1, 1'b0, 4'b0000);
      step();
      idle();
      step();
      step();
      checkOutput("ch0_p3_count2", 4'b0000, 4'b0000, 1'b0);
      applyStimulus(1'b1, 3'd0, 24'd3, 1'b1, 1'b0, 4'b0000);
      step();
      checkOutput("ch0_write_wins", 4'b0000, 4'b0000, 1'b0);
      idle();
      step();
      checkOutput("ch0_rewrite_w1", 4'b0000, 4'b0000, 1'b0);
      step();
      checkOutput("ch0_rewrite_w2", 4'b0000, 4'b0000, 1'b0);
      step();
      checkOutput("ch0_rewrite_w3", 4'b0001, 4'b0001, 1'b1);
      applyStimulus(1'b1, 3'd0, 24'd3, 1'b0, 1'b0, 4'b0001);
      step();
      checkOutput("ch0_p3_stop", 4'b0000, 4'b0000, 1'b0);

      // ch3 period 0: enabled but halted.
      applyStimulus(1'b1, 3'd3, 24'd0, 1'b1, 1'b0, 4'b0000);
      step();
      idle();
      waitQuiet(6, badTicks);
      checkValue("ch3_p0_quiet", badTicks, 0);
      checkOutput("ch3_p0_pend", 4'b0000, 4'b0000, 1'b0);

      // ch3 period 1: tick high every cycle after the write cycle.
      applyStimulus(1'b1, 3'd3, 24'd1, 1'b1, 1'b0, 4'b0000);
      step();
      checkOutput("ch3_p1_write", 4'b0000, 4'b0000, 1'b0);
      idle();
      step();
      checkOutput("ch3_p1_c1", 4'b1000, 4'b1000, 1'b1);
      step();
      checkOutput("ch3_p1_c2", 4'b1000, 4'b1000, 1'b1);

      // Write to index 4 (out of range) must not touch any channel.
      applyStimulus(1'b1, 3'd4, 24'd1, 1'b1, 1'b0, 4'b0000);
      step();
      checkOutput("bad_ch_write", 4'b1000, 4'b1000, 1'b1);
      idle();
      step();
      checkOutput("bad_ch_after", 4'b1000, 4'b1000, 1'b1);

      // Load ch0..ch2 with period 3 so every pend gets set.
      applyStimulus(1'b1, 3'd0, 24'd3, 1'b1, 1'b0, 4'b0000);
      step();
      applyStimulus(1'b1, 3'd1, 24'd3, 1'b1, 1'b0, 4'b0000);
      step();
      applyStimulus(1'b1, 3'd2, 24'd3, 1'b1, 1'b0, 4'b0000);
      step();
      idle();
      step();
      step();
      step();
      checkOutput("all_pend", 4'b1100, 4'b1111, 1'b1);
      step();
      checkOutput("all_pend_next", 4'b1001, 4'b1111, 1'b1);

      // Reset mid-count: everything clears, ch0 restarts at 10_000.
      rst = 1'b1;
      step();
      checkOutput("reset_mid", 4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;
      waitQuiet(9_999, badTicks);
      checkValue("reset_resume_quiet", badTicks, 0);
      step();
      checkOutput("reset_resume_tick", 4'b0001, 4'b0001, 1'b1);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
